// File: rtl/avr_pkg.sv
// Shared state encoding and default memory-map constants for the AVR data-memory path.
package avr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  localparam logic [15:0] DMEM_BASE      = 16'h0060;
  localparam int unsigned DMEM_DEPTH     = 1024;
  localparam logic [7:0]  DMEM_OOB_RDATA = 8'hFF;

endpackage

// File: rtl/avr_dmem_decode.sv
// Combinational SRAM-window check and byte offset for a core data-space address.
// Zero latency, no flow control.
module avr_dmem_decode
  import avr_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE  = DMEM_BASE,
  parameter int unsigned SRAM_DEPTH = DMEM_DEPTH,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic [15:0]       d_addr,
  output logic              in_range,
  output logic [ADDR_W-1:0] offset
);

  // 17-bit limit so a window ending exactly at 64K does not wrap to zero.
  localparam logic [16:0] BASE_EXT  = {1'b0, SRAM_BASE};
  localparam logic [16:0] LIMIT_EXT = BASE_EXT + 17'(SRAM_DEPTH);

  logic [16:0] addr_ext;

  always_comb begin
    addr_ext = {1'b0, d_addr};
    in_range = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    offset   = ADDR_W'(d_addr - SRAM_BASE);
  end

endmodule

// File: rtl/avr_dmem_ctrl.sv
// Maps the AVR data-space SRAM window onto a 1-cycle synchronous single-port SRAM.
// Request to d_ready is two cycles; d_req is ignored during ACCESS, so throughput is one access per two cycles.
module avr_dmem_ctrl
  import avr_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE  = DMEM_BASE,
  parameter int unsigned SRAM_DEPTH = DMEM_DEPTH,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              d_req,
  input  logic [15:0]       d_addr,
  input  logic              data_write,
  inout  wire  [7:0]        data,
  output logic              d_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  input  logic [7:0]        sram_rdata,
  output logic              err_oob,
  input  logic              err_clr
);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic              accept;
  logic              dec_in_range;
  logic [ADDR_W-1:0] dec_offset;
  logic              lat_in_range;
  logic              lat_write;
  logic              drive_bus;

  avr_dmem_decode #(
    .SRAM_BASE  (SRAM_BASE),
    .SRAM_DEPTH (SRAM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_decode (
    .d_addr   (d_addr),
    .in_range (dec_in_range),
    .offset   (dec_offset)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        if (d_req) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes are computed one cycle early so they are flops during ACCESS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lat_in_range <= 1'b0;
      lat_write    <= 1'b0;
      d_ready      <= 1'b0;
      sram_en      <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
      err_oob      <= 1'b0;
    end else begin
      d_ready <= (state == ACCESS);
      sram_en <= accept && dec_in_range;
      sram_we <= accept && dec_in_range && data_write;
      if (accept) begin
        lat_in_range <= dec_in_range;
        lat_write    <= data_write;
        if (dec_in_range) begin
          sram_addr <= dec_offset;
        end
        if (dec_in_range && data_write) begin
          sram_wdata <= data;
        end
      end
      if ((state == RESP) && !lat_in_range) begin
        err_oob <= 1'b1;
      end else if (err_clr) begin
        err_oob <= 1'b0;
      end
    end
  end

  // A core still signalling write during a read response owns the bus; stay off it.
  assign drive_bus = (state == RESP) && !lat_write && !data_write;
  assign data      = drive_bus ? (lat_in_range ? sram_rdata : DMEM_OOB_RDATA) : 8'bz;

endmodule
